mem_port_arbiter: RTL and testbench

//  Shares the single-port 16-bit program/data memory between NREQ requesters
//  (e.g. fetch, load/store, debug loader). Round-robin arbitration, optional

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_picker.sv | 28 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding and default widths.
package mem_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Rotate-priority picker: the first requester after the last grant wins.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            vld,
  output logic [IW-1:0]   win
);

  int idx;

  // Walk from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    vld = 1'b0;
    win = '0;
    idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        vld = 1'b1;
        win = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters,
// with a bounded back-to-back lock and fully registered outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    REQ_WE,
  input  logic [NREQ-1:0]    REQ_LOCK,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]    ACK,
  output logic [DW-1:0]      RDATA,
  output logic               BUSY,
  output logic [AW-1:0]      MEM_ADDR,
  output logic [DW-1:0]      MEM_WDATA,
  output logic               MEM_RD,
  output logic               MEM_WR,
  input  logic [DW-1:0]      MEM_RDATA
);

  localparam int IW = $clog2(NREQ);
  localparam int LW = $clog2(MAX_LOCK + 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;      // last granted requester, also owner of the current access
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_win;
  logic            lock_hit;
  logic            take;
  logic [IW-1:0]   sel;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (REQ),
    .last (last_q),
    .vld  (pick_vld),
    .win  (pick_win)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lock_cnt_d  = lock_cnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    lock_hit    = 1'b0;
    take        = 1'b0;
    sel         = last_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Lock only applies right after an access by the same requester.
        lock_hit = (state_q == ST_DONE) && REQ_LOCK[last_q] && REQ[last_q] &&
                   (int'(lock_cnt_q) < MAX_LOCK - 1);
        if (lock_hit) begin
          take       = 1'b1;
          sel        = last_q;
          lock_cnt_d = lock_cnt_q + LW'(1);
        end else begin
          lock_cnt_d = '0;
          if (pick_vld) begin
            take = 1'b1;
            sel  = pick_win;
          end
        end

        if (take) begin
          last_d      = sel;
          mem_addr_d  = REQ_ADDR[sel*AW +: AW];
          mem_wdata_d = REQ_WDATA[sel*DW +: DW];
          mem_rd_d    = ~REQ_WE[sel];
          mem_wr_d    = REQ_WE[sel];
          busy_d      = 1'b1;
          state_d     = ST_ACCESS;
        end else begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        // Memory reads combinationally; write commits at this edge.
        if (mem_rd_q) rdata_d = MEM_RDATA;
        ack_d[last_q] = 1'b1;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        busy_d        = 1'b0;
        state_d       = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; synchronous active-low reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      last_q      <= IW'(NREQ - 1);
      lock_cnt_q  <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign ACK       = ack_q;
  assign RDATA     = rdata_q;
  assign BUSY      = busy_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_RD    = mem_rd_q;
  assign MEM_WR    = mem_wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model,
// per-cycle strobe checks, directed scenarios then random requester traffic.
module tb_mem_port_arbiter;

  localparam int NREQ     = 3;
  localparam int MAX_LOCK = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic [NREQ-1:0]    req_v = '0, we_v = '0, lk_v = '0;
  logic [NREQ-1:0][15:0] ra = '0, wd = '0;
  logic [NREQ-1:0]    ACK;
  logic [15:0]        RDATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic               BUSY, MEM_RD, MEM_WR;

  mem_port_arbiter #(.NREQ(NREQ), .AW(16), .DW(16), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK(CLK), .RST(RST), .REQ(req_v), .REQ_WE(we_v), .REQ_LOCK(lk_v),
    .REQ_ADDR(ra), .REQ_WDATA(wd), .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Memory behind the DUT, and an independent copy owned by the reference model.
  logic [15:0] dmem [0:65535];
  logic [15:0] rmem [0:65535];
  initial for (int a = 0; a < 65536; a++) begin
    dmem[a] = 16'(a) ^ 16'h0E5A;
    rmem[a] = 16'(a) ^ 16'h0E5A;
  end
  assign MEM_RDATA = dmem[MEM_ADDR];
  always @(posedge CLK) if (RST && MEM_WR) dmem[MEM_ADDR] <= MEM_WDATA;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int g; logic [15:0] rd; } exp_t;
  exp_t q[$];

  logic [NREQ-1:0] exp_ack = '0;
  logic [15:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic exp_busy = 0, exp_rd = 0, exp_wr = 0;
  int  m_last = NREQ - 1, m_run = 0, c;
  bit  m_busy = 0, m_after = 0, found, p_we;
  logic [15:0] p_a, p_d;

  // One access = grant edge, then completion edge; next grant may follow at once.
  initial forever begin
    @(posedge CLK);
    if (!RST) begin
      m_busy = 0; m_after = 0; m_last = NREQ - 1; m_run = 0; q.delete();
      exp_ack = '0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
      exp_busy = 0; exp_rd = 0; exp_wr = 0;
    end else if (m_busy) begin
      if (p_we) rmem[p_a] = p_d;
      else exp_rdata = rmem[p_a];
      exp_ack = '0; exp_ack[m_last] = 1'b1;
      exp_busy = 0; exp_rd = 0; exp_wr = 0;
      m_busy = 0; m_after = 1;
    end else begin
      exp_ack = '0;
      found = 0;
      if (m_after && lk_v[m_last] && req_v[m_last] && m_run < MAX_LOCK - 1) begin
        found = 1; m_run++;
      end else begin
        m_run = 0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (!found && req_v[c]) begin found = 1; m_last = c; end
        end
      end
      if (found) begin
        p_we = we_v[m_last]; p_a = ra[m_last]; p_d = wd[m_last];
        exp_addr = p_a; exp_wdata = p_d; exp_rd = !p_we; exp_wr = p_we;
        exp_busy = 1; m_busy = 1;
        q.push_back('{m_last, p_we ? exp_rdata : rmem[p_a]});
      end else begin
        exp_rd = 0; exp_wr = 0; exp_busy = 0;
      end
      m_after = 0;
    end
  end

  // ---------------- monitor ----------------
  exp_t e;
  initial forever begin
    @(negedge CLK);
    chk("busy", 32'(BUSY), 32'(exp_busy));
    chk("mem_rd", 32'(MEM_RD), 32'(exp_rd));
    chk("mem_wr", 32'(MEM_WR), 32'(exp_wr));
    chk("mem_addr", 32'(MEM_ADDR), 32'(exp_addr));
    chk("mem_wdata", 32'(MEM_WDATA), 32'(exp_wdata));
    chk("ack", 32'(ACK), 32'(exp_ack));
    chk("rdata", 32'(RDATA), 32'(exp_rdata));
    if (ACK != '0) begin
      if (q.size() == 0) chk("unexpected_ack", 32'(ACK), 32'h0);
      else begin
        e = q.pop_front();
        chk("sb_ack", 32'(ACK), 32'(1) << e.g);
        chk("sb_rdata", 32'(RDATA), 32'(e.rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input int i, input bit we, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd);
    bit got = 0;
    req_v[i] = 1'b1; we_v[i] = we; ra[i] = a; wd[i] = d;
    rd = 'x;
    for (int cy = 0; cy < 20 && !got; cy++) begin
      @(negedge CLK);
      if (ACK[i]) begin got = 1; rd = RDATA; end
    end
    req_v[i] = 1'b0;
    if (!got) chk("ack_timeout", 32'(i), 32'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b0; req_v = '0; lk_v = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  int order[$];
  logic [15:0] rd;
  int n;

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // Single read from requester 1.
    do_req(1, 0, 16'h05AA, 16'h0, rd);
    chk("t1_rdata", 32'(rd), 32'h0BF0);

    // Write then read back through requester 0.
    do_req(0, 1, 16'h0010, 16'h1234, rd);
    do_req(0, 0, 16'h0010, 16'h0, rd);
    chk("t2_rdata", 32'(rd), 32'h1234);

    // All three requesting continuously: strict rotation from 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin we_v[i] = 0; ra[i] = 16'(16'h100 + i); end
    req_v = '1;
    order.delete();
    for (int cy = 0; cy < 30 && order.size() < 6; cy++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) if (ACK[i]) order.push_back(i);
    end
    req_v = '0;
    chk("t3_count", 32'(order.size()), 32'd6);
    for (int k = 0; k < 6 && k < order.size(); k++) chk("t3_order", 32'(order[k]), 32'(k % 3));

    // Locked requester 2 keeps the port for MAX_LOCK accesses while 0 waits.
    @(negedge CLK);
    we_v[2] = 0; ra[2] = 16'h0200; lk_v[2] = 1; req_v[2] = 1;
    @(negedge CLK);
    we_v[0] = 0; ra[0] = 16'h0300; req_v[0] = 1;
    order.delete();
    for (int cy = 0; cy < 30 && order.size() < 5; cy++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) if (ACK[i]) order.push_back(i);
    end
    req_v = '0; lk_v = '0;
    chk("t4_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      chk("t4_order", 32'(order[k]), (k < 4) ? 32'd2 : 32'd0);

    // Reset during the access of a write aborts it.
    @(negedge CLK);
    we_v[0] = 1; ra[0] = 16'h0020; wd[0] = 16'hBEEF; req_v[0] = 1;
    @(negedge CLK);
    chk("t5_busy", 32'(BUSY), 32'd1);
    RST = 1'b0; req_v = '0;
    @(negedge CLK);
    chk("t5_ack", 32'(ACK), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    we_v[0] = 0; we_v[1] = 0; ra[0] = 16'h0020; ra[1] = 16'h0021; req_v = 3'b011;
    n = -1;
    for (int cy = 0; cy < 10 && n < 0; cy++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) if (ACK[i]) n = i;
    end
    req_v = '0;
    chk("t5_first", 32'(n), 32'd0);
    chk("t5_mem", 32'(RDATA), 32'h0E7A);

    // Requester drops its request during the access.
    @(negedge CLK);
    we_v[1] = 0; ra[1] = 16'h0030; req_v[1] = 1;
    @(negedge CLK);
    req_v[1] = 0;
    n = 0;
    for (int cy = 0; cy < 8; cy++) begin
      @(negedge CLK);
      if (ACK[1]) n++;
    end
    chk("t6_acks", 32'(n), 32'd1);

    // Random requester traffic, with occasional resets.
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (ACK[i] || !req_v[i]) begin
          req_v[i] = ($urandom_range(0, 2) != 0);
          we_v[i]  = $urandom_range(0, 1);
          ra[i]    = 16'($urandom_range(0, 15));
          wd[i]    = 16'($urandom);
        end else if (BUSY && $urandom_range(0, 19) == 0) begin
          req_v[i] = 0;
        end
        if ($urandom_range(0, 3) == 0) lk_v[i] = $urandom_range(0, 1);
      end
    end
    RST = 1'b1; req_v = '0; lk_v = '0;
    repeat (6) @(negedge CLK);
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
